// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell plus a registered carry,
// processing operands LSB first and strobing done once the sum is ready.
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [N-1:0]   acc;
  logic [N-1:0]   acc_next;
  logic           carry;
  logic           carry_next;
  logic           bit_sum;
  logic           last_bit;
  logic           accept;
  logic [CW-1:0]  count;

  assign bit_sum    = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last_bit   = (count == CW'(N - 1));
  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign busy       = (state == SHIFT);
  assign done       = (state == DONE);

  // Written as a shift plus MSB insert so the N=1 case needs no special slice.
  always_comb begin
    acc_next        = acc >> 1;
    acc_next[N-1]   = bit_sum;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Start is only honoured in IDLE/DONE, so operands in flight stay intact.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      acc   <= '0;
      carry <= cin;
      count <= '0;
    end else if (state == SHIFT) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      acc   <= acc_next;
      carry <= carry_next;
      count <= count + CW'(1);
      if (last_bit) begin
        sum  <= acc_next;
        cout <= carry_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: N=8 and N=1 instances, table-driven
// vectors plus hand-written multi-cycle sequences, scoreboard on done.
module tb_serial_adder;

  localparam int N = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec8_t;

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic cout;
    logic sum;
  } vec1_t;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, a1, b1, cin1, busy1, done1, sum1, cout1;

  int compared = 0;
  int mismatched = 0;
  int done8_count = 0;
  int done1_count = 0;
  int cycle = 0;

  logic [8:0] exp_q8[$];
  logic [1:0] exp_q1[$];
  logic [8:0] e8;
  logic [1:0] e1;

  vec8_t vecs8[8];
  vec1_t vecs1[8];

  serial_adder #(.N(8)) dut8 (
    .clk(clk), .n_reset(n_reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.N(1)) dut1 (
    .clk(clk), .n_reset(n_reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every done strobe pops the oldest expected result.
  always @(negedge clk) begin
    if (n_reset === 1'b1) begin
      if (done8 === 1'b1) begin
        done8_count++;
        check_output("done8_with_busy8", 32'(busy8), 32'd0);
        if (exp_q8.size() == 0) begin
          check_output("unexpected_done8", 32'd1, 32'd0);
        end else begin
          e8 = exp_q8.pop_front();
          check_output("result8", 32'({cout8, sum8}), 32'(e8));
        end
      end
      if (done1 === 1'b1) begin
        done1_count++;
        check_output("done1_with_busy1", 32'(busy1), 32'd0);
        if (exp_q1.size() == 0) begin
          check_output("unexpected_done1", 32'd1, 32'd0);
        end else begin
          e1 = exp_q1.pop_front();
          check_output("result1", 32'({cout1, sum1}), 32'(e1));
        end
      end
    end
  end

  task automatic apply_stimulus8(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic [8:0] expected);
    int lat;
    int busy_cycles;
    bit seen;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    exp_q8.push_back(expected);
    lat = 0; busy_cycles = 0; seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (busy8) busy_cycles++;
      if (done8) begin
        seen = 1;
        lat = i;
      end
    end
    check_output("latency8", 32'(lat), 32'(N + 1));
    check_output("busy_cycles8", 32'(busy_cycles), 32'(N));
  endtask

  task automatic apply_stimulus1(input logic a, input logic b, input logic cin,
                                 input logic [1:0] expected);
    int lat;
    int busy_cycles;
    bit seen;
    @(negedge clk);
    a1 = a; b1 = b; cin1 = cin; start1 = 1'b1;
    exp_q1.push_back(expected);
    lat = 0; busy_cycles = 0; seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (busy1) busy_cycles++;
      if (done1) begin
        seen = 1;
        lat = i;
      end
    end
    check_output("latency1", 32'(lat), 32'd2);
    check_output("busy_cycles1", 32'(busy_cycles), 32'd1);
  endtask

  initial begin
    int base;
    int last_cycle;
    bit seen;
    logic [7:0] bb_a[4];
    logic [7:0] bb_b[4];
    logic       bb_c[4];
    logic [8:0] bb_e[4];

    vecs8[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs8[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs8[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs8[6] = '{8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1};
    vecs8[7] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    vecs1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs1[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs1[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs1[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs1[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs1[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs1[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    bb_a = '{8'h10, 8'hFF, 8'h01, 8'hC8};
    bb_b = '{8'h20, 8'hFF, 8'h02, 8'h64};
    bb_c = '{1'b0, 1'b0, 1'b1, 1'b0};
    bb_e = '{9'h030, 9'h1FE, 9'h004, 9'h12C};

    n_reset = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    #12;
    check_output("reset_busy8", 32'(busy8), 32'd0);
    check_output("reset_done8", 32'(done8), 32'd0);
    check_output("reset_result8", 32'({cout8, sum8}), 32'd0);
    check_output("reset_result1", 32'({busy1, done1, cout1, sum1}), 32'd0);
    #10 n_reset = 1'b1;

    $display("[TB] table vectors, N=8");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus8(vecs8[i].a, vecs8[i].b, vecs8[i].cin, {vecs8[i].cout, vecs8[i].sum});
    end
    repeat (5) @(negedge clk);
    check_output("hold_result8", 32'({cout8, sum8}), 32'h080);

    $display("[TB] start ignored during shift");
    base = done8_count;
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    exp_q8.push_back(9'h046);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (20) @(negedge clk);
    check_output("single_done_midshift", 32'(done8_count - base), 32'd1);
    check_output("midshift_result_held", 32'({cout8, sum8}), 32'h046);

    $display("[TB] async reset during shift");
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    exp_q8.push_back(9'h088);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("busy_before_reset", 32'(busy8), 32'd1);
    #2 n_reset = 1'b0;
    if (exp_q8.size() > 0) void'(exp_q8.pop_back());
    #1;
    check_output("async_reset_busy8", 32'(busy8), 32'd0);
    check_output("async_reset_done8", 32'(done8), 32'd0);
    check_output("async_reset_result8", 32'({cout8, sum8}), 32'd0);
    base = done8_count;
    repeat (3) @(negedge clk);
    #2 n_reset = 1'b1;
    repeat (12) @(negedge clk);
    check_output("no_done_after_reset", 32'(done8_count - base), 32'd0);
    apply_stimulus8(8'h01, 8'h01, 1'b0, 9'h002);

    $display("[TB] start held high, back-to-back");
    @(negedge clk);
    a8 = bb_a[0]; b8 = bb_b[0]; cin8 = bb_c[0]; start8 = 1'b1;
    exp_q8.push_back(bb_e[0]);
    last_cycle = 0;
    for (int op = 0; op < 4; op++) begin
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (done8) seen = 1;
      end
      if (!seen) begin
        check_output("b2b_done_timeout", 32'd0, 32'd1);
        break;
      end
      if (op > 0) check_output("b2b_period", 32'(cycle - last_cycle), 32'(N + 1));
      last_cycle = cycle;
      if (op < 3) begin
        a8 = bb_a[op + 1]; b8 = bb_b[op + 1]; cin8 = bb_c[op + 1];
        exp_q8.push_back(bb_e[op + 1]);
      end else begin
        start8 = 1'b0;
      end
    end

    $display("[TB] table vectors, N=1");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus1(vecs1[i].a, vecs1[i].b, vecs1[i].cin, {vecs1[i].cout, vecs1[i].sum});
    end

    repeat (4) @(negedge clk);
    check_output("leftover_expected8", 32'(exp_q8.size()), 32'd0);
    check_output("leftover_expected1", 32'(exp_q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
